// File: rtl/soc_nios2_cpu_debug_scan_engine.sv
// Single-clock debug scan engine: capture, DR shift and update handshake.
// Define DEBUG_SCAN_PARITY_EN to make sr[DR_W-1] an even-parity bit.
module soc_nios2_cpu_debug_scan_engine #(
    parameter int DR_W  = 38,
    parameter int IR_W  = 2,
    parameter int CNT_W = 7,
    localparam int NUM_IR = 2 ** IR_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   vs_uir,
    input  logic                   vs_cdr,
    input  logic                   vs_sdr,
    input  logic                   vs_udr,
    input  logic [IR_W-1:0]        ir_in,
    input  logic                   tdi,
    input  logic [NUM_IR*DR_W-1:0] cap_data,
    output logic                   tdo,
    output logic [1:0]             ir_out,
    output logic [DR_W-1:0]        jdo,
    output logic                   action_valid,
    output logic [NUM_IR-1:0]      action_sel,
    input  logic                   action_ready,
    output logic                   short_scan,
    output logic                   overrun
`ifdef DEBUG_SCAN_PARITY_EN
    ,
    output logic                   parity_err
`endif
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t            state, state_nxt;
    logic [DR_W-1:0]   sr, sr_nxt;
    logic [DR_W-1:0]   jdo_nxt;
    logic [DR_W-1:0]   defer_word, defer_word_nxt;
    logic              defer, defer_nxt;
    logic [CNT_W-1:0]  shift_cnt, cnt_nxt;
    logic [IR_W-1:0]   ir_reg, ir_nxt;
    logic [NUM_IR-1:0] sel_nxt, ir_onehot;
    logic              valid_nxt, short_nxt, ovr_nxt;
    logic              do_udr, short_now, par_ok, word_ok;
    logic [DR_W-1:0]   word;
    logic [DR_W-1:0]   cap_arr [NUM_IR];

    for (genvar k = 0; k < NUM_IR; k++) begin : g_cap
        assign cap_arr[k] = cap_data[k*DR_W +: DR_W];
    end

    assign do_udr    = vs_udr & ~vs_uir & ~vs_cdr & ~vs_sdr;
    assign short_now = (shift_cnt != CNT_W'(DR_W));

`ifdef DEBUG_SCAN_PARITY_EN
    assign par_ok = ~^sr;
    assign word   = {1'b0, sr[DR_W-2:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            parity_err <= 1'b0;
        else if (vs_uir)
            parity_err <= 1'b0;
        else if (do_udr && !short_now && !par_ok)
            parity_err <= 1'b1;
    end
`else
    assign par_ok = 1'b1;
    assign word   = sr;
`endif

    assign word_ok = ~short_now & par_ok;
    assign tdo     = sr[0];
    assign ir_out  = {overrun, action_valid};

    always_comb begin
        ir_onehot         = '0;
        ir_onehot[ir_reg] = 1'b1;
    end

    always_comb begin
        state_nxt      = state;
        sr_nxt         = sr;
        cnt_nxt        = shift_cnt;
        ir_nxt         = ir_reg;
        jdo_nxt        = jdo;
        sel_nxt        = action_sel;
        valid_nxt      = action_valid;
        short_nxt      = short_scan;
        ovr_nxt        = overrun;
        defer_nxt      = 1'b0;
        defer_word_nxt = defer_word;

        if (vs_uir) begin
            ir_nxt    = ir_in;
            ovr_nxt   = 1'b0;
            short_nxt = 1'b0;
        end else if (vs_cdr) begin
            sr_nxt  = cap_arr[ir_reg];
            cnt_nxt = '0;
        end else if (vs_sdr) begin
            sr_nxt = {tdi, sr[DR_W-1:1]};
            if (shift_cnt != '1)
                cnt_nxt = shift_cnt + 1'b1;
        end else if (vs_udr) begin
            short_nxt = short_now;
        end

        unique case (state)
            IDLE: begin
                // An update that raced a ready in HOLD is taken here.
                if (defer) begin
                    jdo_nxt   = defer_word;
                    sel_nxt   = ir_onehot;
                    valid_nxt = 1'b1;
                    state_nxt = HOLD;
                    if (do_udr)
                        ovr_nxt = 1'b1;
                end else if (do_udr && word_ok) begin
                    jdo_nxt   = word;
                    sel_nxt   = ir_onehot;
                    valid_nxt = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (action_ready) begin
                    valid_nxt = 1'b0;
                    state_nxt = IDLE;
                    if (do_udr && word_ok) begin
                        defer_nxt      = 1'b1;
                        defer_word_nxt = word;
                    end
                end else if (do_udr) begin
                    ovr_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            sr           <= '0;
            shift_cnt    <= '0;
            ir_reg       <= '0;
            jdo          <= '0;
            action_sel   <= '0;
            action_valid <= 1'b0;
            short_scan   <= 1'b0;
            overrun      <= 1'b0;
            defer        <= 1'b0;
            defer_word   <= '0;
        end else begin
            state        <= state_nxt;
            sr           <= sr_nxt;
            shift_cnt    <= cnt_nxt;
            ir_reg       <= ir_nxt;
            jdo          <= jdo_nxt;
            action_sel   <= sel_nxt;
            action_valid <= valid_nxt;
            short_scan   <= short_nxt;
            overrun      <= ovr_nxt;
            defer        <= defer_nxt;
            defer_word   <= defer_word_nxt;
        end
    end

endmodule
